program_loader: RTL

Writable 16 x 3-bit program store that replaces the fixed program constants feeding instruction fetch. An external host streams 3-bit program words in over a valid/ready handshake; the block writes them sequentially from address 0 and reports completion. Fetch reads an aligned opcode/operand pair through a combinational read port. `cpu_hold` stalls the core while a load is in progress.

---
 rtl/program_loader_if.sv | 41 ++++
 rtl/program_loader.sv | 111 +++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
//   Groups the host load stream and the fetch read port of program_loader.
//   master : host/fetch side (drives load requests, words, read address)
//   slave  : program_loader (returns ready, status and the fetched pair)
//
//   load_start  host -> loader   1-cycle request to begin a new load
//   in_valid    host -> loader   a program word is present on in_data
//   in_data     host -> loader   3-bit word (opcode even addr, operand odd)
//   in_last     host -> loader   marks the final word of the program
//   in_ready    loader -> host   word is accepted this cycle
//   loaded      loader -> host   a complete program is present
//   prog_len    loader -> host   word count of the last completed load
//   cpu_hold    loader -> core   stall the core while no program is present
//   rd_addr     fetch -> loader  instruction pointer
//   rd_opcode   loader -> fetch  word at {rd_addr[3:1],0}
//   rd_operand  loader -> fetch  word at {rd_addr[3:1],1}
// ---------------------------------------------------------------------------
interface program_loader_if;
  logic       load_start;
  logic       in_valid;
  logic [2:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       loaded;
  logic [4:0] prog_len;
  logic       cpu_hold;
  logic [3:0] rd_addr;
  logic [2:0] rd_opcode;
  logic [2:0] rd_operand;

  modport master (
    output load_start, in_valid, in_data, in_last, rd_addr,
    input  in_ready, loaded, prog_len, cpu_hold, rd_opcode, rd_operand
  );

  modport slave (
    input  load_start, in_valid, in_data, in_last, rd_addr,
    output in_ready, loaded, prog_len, cpu_hold, rd_opcode, rd_operand
  );
endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Writable 16 x 3-bit program store feeding instruction fetch. A host
//   streams words in over a valid/ready handshake; they are written
//   sequentially from address 0. The load ends on in_last or on the 16th
//   word. Fetch reads an aligned opcode/operand pair combinationally.
//
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : program_loader_if.slave (load stream, status, read port)
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  program_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [4:0] wr_ptr_reg, wr_ptr_next;
  logic [4:0] prog_len_reg, prog_len_next;
  logic [2:0] mem_reg [DEPTH];

  logic       in_ready;
  logic       clear_mem;
  logic       wr_en;
  logic [3:0] even_addr;
  logic [3:0] odd_addr;

  // load_start masks ready so a restart and a handshake never share a cycle.
  assign in_ready = (state_reg == LOAD) && !bus.load_start;

  // ---------------------------------------------------------------------------
  // State and pointer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= 5'd0;
      prog_len_reg <= 5'd0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      prog_len_reg <= prog_len_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    prog_len_next = prog_len_reg;
    clear_mem     = 1'b0;
    wr_en         = 1'b0;

    if (bus.load_start) begin
      // prog_len deliberately keeps the previous length until completion.
      clear_mem   = 1'b1;
      wr_ptr_next = 5'd0;
      state_next  = LOAD;
    end else if (bus.in_valid && in_ready) begin
      wr_en       = 1'b1;
      wr_ptr_next = wr_ptr_reg + 5'd1;
      // The 16th word always terminates, so no write can pass address 15.
      if (bus.in_last || (wr_ptr_reg[3:0] == 4'd15)) begin
        state_next    = DONE;
        prog_len_next = wr_ptr_reg + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Program storage: one register per word so a restart can clear all at once
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (rst || clear_mem) begin
          mem_reg[gi] <= 3'd0;
        end else if (wr_en && (wr_ptr_reg[3:0] == 4'(gi))) begin
          mem_reg[gi] <= bus.in_data;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign even_addr = {bus.rd_addr[3:1], 1'b0};
  assign odd_addr  = {bus.rd_addr[3:1], 1'b1};

  // A misaligned (odd) pointer fetches nothing rather than a shifted pair.
  assign bus.rd_opcode  = bus.rd_addr[0] ? 3'd0 : mem_reg[even_addr];
  assign bus.rd_operand = bus.rd_addr[0] ? 3'd0 : mem_reg[odd_addr];

  assign bus.in_ready = in_ready;
  assign bus.loaded   = (state_reg == DONE);
  assign bus.cpu_hold = (state_reg != DONE);
  assign bus.prog_len = prog_len_reg;

endmodule
